// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment capture path: glyph table, dp bit position, FSM states.
package seg7_pkg;

    localparam int SEG_DP_BIT = 7;

    // Segment pattern (bit0=a .. bit6=g) for each hex nibble, indexed by nibble value.
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

endpackage

// File: rtl/seg7_capture_if.sv
// Multiplexed display bus plus the rebuilt per-digit view produced by the capture block.
interface seg7_capture_if #(
    parameter int NDIG = 4
);
    logic [7:0]        seg;
    logic [NDIG-1:0]   an;
    logic [4*NDIG-1:0] hex;
    logic [NDIG-1:0]   dp;
    logic [NDIG-1:0]   valid;
    logic [NDIG-1:0]   err;
    logic              upd;
    logic [2:0]        upd_idx;

    modport master (output seg, an, input hex, dp, valid, err, upd, upd_idx);
    modport slave  (input seg, an, output hex, dp, valid, err, upd, upd_idx);
endinterface

// File: rtl/seg7_glyph_encode.sv
// Maps a 7-bit segment pattern back to its hex nibble; legal=0 for anything not in the glyph table.
module seg7_glyph_encode
    import seg7_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] nib,
    output logic       legal
);

    always_comb begin
        nib   = '0;
        legal = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pat == GLYPH[i]) begin
                nib   = 4'(i);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// Watches a multiplexed 7-segment bus and rebuilds the nibble and dp shown on each digit
// once the bus has been stable for STABLE_CYC clocks.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    seg7_capture_if.slave  bus
);

    localparam int         W    = NDIG + 8;
    localparam int         IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [7:0] LAST = 8'(STABLE_CYC - 1);

    logic [W-1:0]      sync_p0, sync_p1, prev_p2;
    logic [NDIG-1:0]   s_an;
    logic [7:0]        s_seg;
    logic              chg, onehot, cap;
    logic [7:0]        cnt_p2;
    state_t            state, state_nxt;
    logic [IW-1:0]     ki;
    logic [3:0]        nib;
    logic              legal;

    logic [4*NDIG-1:0] hex_r;
    logic [NDIG-1:0]   dp_r, valid_r, err_r;
    logic              upd_r;
    logic [2:0]        upd_idx_r;

    assign {s_an, s_seg} = sync_p1;
    assign chg           = (sync_p1 != prev_p2);
    assign onehot        = $onehot(s_an);

    // Stage p0/p1: two-flop synchroniser; p2: previous synchronised value for change detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            prev_p2 <= '0;
        end else begin
            sync_p0 <= {bus.an, bus.seg};
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               cnt_p2 <= '0;
        else if (chg)             cnt_p2 <= '0;
        else if (cnt_p2 != 8'hFF) cnt_p2 <= cnt_p2 + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Any change re-arms the settle; HOLD only leaves on a change, so a static bus captures once.
    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        case (state)
            IDLE: begin
                if (chg && onehot) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (chg) begin
                    state_nxt = onehot ? SETTLE : IDLE;
                end else if (cnt_p2 == LAST) begin
                    cap       = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (chg) state_nxt = onehot ? SETTLE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ki = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (s_an[i]) ki = IW'(i);
        end
    end

    seg7_glyph_encode u_enc (
        .pat   (s_seg[6:0]),
        .nib   (nib),
        .legal (legal)
    );

    // Capture stage: only the enabled digit is written; an illegal glyph keeps the last good nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_r     <= '0;
            dp_r      <= '0;
            valid_r   <= '0;
            err_r     <= '0;
            upd_r     <= 1'b0;
            upd_idx_r <= '0;
        end else begin
            upd_r <= cap;
            if (cap) begin
                upd_idx_r <= 3'(ki);
                dp_r[ki]  <= s_seg[SEG_DP_BIT];
                if (legal) begin
                    hex_r[4*ki +: 4] <= nib;
                    valid_r[ki]      <= 1'b1;
                    err_r[ki]        <= 1'b0;
                end else begin
                    err_r[ki] <= 1'b1;
                end
            end
        end
    end

    assign bus.hex     = hex_r;
    assign bus.dp      = dp_r;
    assign bus.valid   = valid_r;
    assign bus.err     = err_r;
    assign bus.upd     = upd_r;
    assign bus.upd_idx = upd_idx_r;

endmodule
